chunked_serial_adder: RTL

- Parametrised multi-cycle adder/subtractor for WIDTH-bit operands.
- Processes CHUNK bits per clock, LSB chunk first, with carry held in a register between chunks.
- Trades latency for area against the flat ripple adder. Used where wide adds are infrequent and operands arrive through a start/done handshake from a controller.
- Adds subtract mode, signed-overflow flag and registered, held results.

---
 rtl/chunked_serial_adder.sv | 123 ++++++++++++
 1 files changed

// File: rtl/chunked_serial_adder.sv
// rtl/chunked_serial_adder.sv - multi-cycle chunked adder/subtractor with start/done handshake
module chunked_serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_chunk
    $error("chunked_serial_adder: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, psum_q, psum_d, s_q, s_d;
  logic             carry_q, carry_d, cmsb_q, cmsb_d;
  logic             cout_q, cout_d, v_q, v_d, done_q, done_d;
  logic [KW-1:0]    k_q, k_d;

  int               base;
  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic [CHUNK:0]   chunk_sum;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    psum_d  = psum_q;
    carry_d = carry_q;
    cmsb_d  = cmsb_q;
    k_d     = k_q;
    s_d     = s_q;
    cout_d  = cout_q;
    v_d     = v_q;
    done_d  = 1'b0;

    base      = int'(k_q) * CHUNK;
    a_chunk   = a_q[base +: CHUNK];
    b_chunk   = b_q[base +: CHUNK];
    chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = sub ? ~B : B;
          carry_d = sub ? 1'b1 : Cin;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        psum_d[base +: CHUNK] = chunk_sum[CHUNK-1:0];
        carry_d = chunk_sum[CHUNK];
        if (k_q == KW'(NCHUNK - 1)) begin
          // Carry into the MSB recovered from the sum bit and its two operand bits.
          cmsb_d  = chunk_sum[CHUNK-1] ^ a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1];
          state_d = FIN;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      FIN: begin
        done_d  = 1'b1;
        s_d     = psum_q;
        cout_d  = carry_q;
        v_d     = cmsb_q ^ carry_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      psum_q  <= '0;
      carry_q <= 1'b0;
      cmsb_q  <= 1'b0;
      k_q     <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      v_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      psum_q  <= psum_d;
      carry_q <= carry_d;
      cmsb_q  <= cmsb_d;
      k_q     <= k_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      v_q     <= v_d;
      done_q  <= done_d;
    end
  end

  assign ready = (state_q == IDLE);
  assign done  = done_q;
  assign S     = s_q;
  assign Cout  = cout_q;
  assign V     = v_q;

endmodule
